branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Fetch-side counterpart to the EX-stage branch condition unit: predicts taken/not-taken and target for the fetch PC, then consumes the resolved branch outcome from EX to train itself.
- Direct-mapped branch target buffer with one 2-bit saturating counter per entry.
- Flags mispredictions so the pipeline can flush IF/ID and redirect fetch.

Parameters:
- INDEX_BITS, 4, log2 of entry count (16 entries).
- PC_W, 32, PC width; PCs are word-aligned, bits [1:0] ignored.
- CNT_W, 16, width of the saturating mispredict counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- if_pc  in  PC_W  PC currently being fetched.
- pred_hit  out  1  if_pc matches a valid entry.
- pred_taken  out  1  prediction is taken.
- pred_target  out  PC_W  predicted target; if_pc+4 when not taken.
- upd_valid  in  1  an EX-stage branch resolves this cycle.
- upd_pc  in  PC_W  PC of the resolving branch.
- upd_taken  in  1  resolved outcome (branch_condition from EX).
- upd_target  in  PC_W  computed branch target.
- upd_pred_taken  in  1  prediction made for this branch, carried down the pipeline.
- upd_pred_target  in  PC_W  predicted target carried down the pipeline.
- mispredict  out  1  flush request, combinational from the upd_* inputs.
- redirect_pc  out  PC_W  correct next PC when mispredict=1.
- mispredict_count  out  CNT_W  saturating count of mispredicts.

Behaviour:
- Address split:
  - index = pc[INDEX_BITS+1:2]
  - tag = pc[PC_W-1:INDEX_BITS+2]
- Entry contents: valid, tag, target, cnt[1:0].
- Prediction path (combinational, zero latency):
  - pred_hit = valid[idx] & (tag[idx] == if_tag).
  - pred_taken = pred_hit & cnt[idx][1].
  - pred_target = pred_taken ? target[idx] : if_pc+4. The +4 wraps modulo 2^PC_W.
- While rst=0: pred_hit=0, pred_taken=0, pred_target=if_pc+4.
- Update path (registered, applied at the clock edge when upd_valid=1 and rst=1):
  - Hit, taken: cnt increments and saturates at 2'b11; target <= upd_target.
  - Hit, not taken: cnt decrements and saturates at 2'b00; target is unchanged.
  - Miss, taken: allocate the entry by overwriting any conflicting tag. valid=1, tag, target=upd_target, cnt=2'b10 (weakly taken).
  - Miss, not taken: no change.
- Read/write collision: when if_pc and upd_pc hit the same index in one cycle, the prediction uses pre-update contents. The write becomes visible the next cycle, with no bypass.
- mispredict = upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & upd_target != upd_pred_target)).
  - Combinational.
  - Forced to 0 while rst=0.
- redirect_pc = upd_taken ? upd_target : upd_pc+4.
- mispredict_count:
  - Increments at each clock edge where mispredict=1.
  - Saturates at all-ones.
  - Clears to 0 on reset.
- Reset (synchronous, any cycle, including mid-update):
  - All valid<=0 and all cnt<=2'b01.
  - Tags and targets cleared to 0.
  - mispredict_count<=0.
  - An upd_valid present during the reset cycle is discarded.
- No handshake or stall: every asserted upd_valid is consumed in its cycle.

Test Plan:
- Reset, then if_pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104, mispredict_count=0.
- Update upd_pc=0x100, taken, target=0x40, pred_taken=0 -> mispredict=1, redirect_pc=0x40, count=1. Next cycle, if_pc=0x100 -> hit, taken, pred_target=0x40.
- Hysteresis at 0x100:
  - Two taken updates -> cnt=11.
  - One not-taken update -> still predicts taken.
  - Second not-taken update -> pred_taken=0, pred_target=0x104.
  - At the not-taken mispredict, redirect_pc=0x104.
- Aliasing:
  - Allocate 0x100 then 0x140 (same index 0, INDEX_BITS=4) -> 0x100 misses, 0x140 hits.
  - Not-taken update to unseen 0x200 -> no allocation.
- Same-cycle collision: if_pc=upd_pc=0x100 with a first-time taken update -> that cycle pred_hit=0; next cycle pred_hit=1.
- Taken/taken target mismatch (pred_target 0x40, actual 0x80) -> mispredict=1, redirect_pc=0x80.
- Reset asserted with upd_valid=1 -> table cleared, no allocation.
- Drive 0xFFFF+2 mispredicts -> mispredict_count holds 0xFFFF.

Source files
------------

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: a direct-mapped BTB with 2-bit saturating counters,
// trained from resolved EX-stage branches, plus misprediction flagging and counting.
module branch_predictor #(
  parameter int INDEX_BITS = 4,
  parameter int PC_W       = 32,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   if_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_target,
  input  logic              upd_valid,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic              upd_taken,
  input  logic [PC_W-1:0]   upd_target,
  input  logic              upd_pred_taken,
  input  logic [PC_W-1:0]   upd_pred_target,
  output logic              mispredict,
  output logic [PC_W-1:0]   redirect_pc,
  output logic [CNT_W-1:0]  mispredict_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = PC_W - INDEX_BITS - 2;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [PC_W-1:0]  target_q [ENTRIES];
  logic [1:0]       cnt_q    [ENTRIES];

  logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

  logic [INDEX_BITS-1:0] if_idx, upd_idx;
  logic [TAG_W-1:0]      if_tag, upd_tag;
  logic                  upd_hit;
  logic                  unused_pc_bits;

  assign if_idx  = if_pc[INDEX_BITS+1:2];
  assign if_tag  = if_pc[PC_W-1:INDEX_BITS+2];
  assign upd_idx = upd_pc[INDEX_BITS+1:2];
  assign upd_tag = upd_pc[PC_W-1:INDEX_BITS+2];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // PCs are word-aligned; the byte-offset bits carry no information.
  assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

  // Prediction reads the pre-update table, so a same-cycle write is seen next cycle.
  always_comb begin
    pred_hit    = 1'b0;
    pred_taken  = 1'b0;
    pred_target = if_pc + PC_W'(4);
    if (rst) begin
      pred_hit   = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
      pred_taken = pred_hit && cnt_q[if_idx][1];
      if (pred_taken) pred_target = target_q[if_idx];
    end
  end

  always_comb begin
    mispredict  = rst && upd_valid &&
                  ((upd_taken != upd_pred_taken) ||
                   (upd_taken && (upd_target != upd_pred_target)));
    redirect_pc = upd_taken ? upd_target : upd_pc + PC_W'(4);
    mispredict_count_d = mispredict_count_q;
    if (mispredict && (mispredict_count_q != '1))
      mispredict_count_d = mispredict_count_q + CNT_W'(1);
  end

  assign mispredict_count = mispredict_count_q;

  // NOTE: the table is held in flops and reset explicitly; valid bits must clear
  // on reset, and non-blocking assignments keep every update edge-ordered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= 2'b01;
      end
      mispredict_count_q <= '0;
    end else begin
      mispredict_count_q <= mispredict_count_d;
      if (upd_valid) begin
        if (upd_hit) begin
          if (upd_taken) begin
            if (cnt_q[upd_idx] != 2'b11) cnt_q[upd_idx] <= cnt_q[upd_idx] + 2'd1;
            target_q[upd_idx] <= upd_target;
          end else if (cnt_q[upd_idx] != 2'b00) begin
            cnt_q[upd_idx] <= cnt_q[upd_idx] - 2'd1;
          end
        end else if (upd_taken) begin
          valid_q[upd_idx]  <= 1'b1;
          tag_q[upd_idx]    <= upd_tag;
          target_q[upd_idx] <= upd_target;
          cnt_q[upd_idx]    <= 2'b10;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: the driver pushes model predictions per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid, upd_taken, upd_pred_taken;
  logic [31:0] upd_pc, upd_target, upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [15:0] mispredict_count;

  branch_predictor dut (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          valid;
    int unsigned tag;
    logic [31:0] target;
    int          conf;
  } entry_t;

  typedef struct {
    logic        hit;
    logic        taken;
    logic [31:0] target;
    logic        misp;
    logic [31:0] redir;
    logic [15:0] count;
  } exp_t;

  entry_t      tbl [16];
  int unsigned m_count = 0;
  exp_t        sb [$];
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      tbl[i].valid = 0; tbl[i].tag = 0; tbl[i].target = 0; tbl[i].conf = 1;
    end
    m_count = 0;
  endfunction

  function automatic void predict(input logic [31:0] pc, output bit hit, output bit taken,
                                  output logic [31:0] tgt);
    int idx;
    idx   = int'((pc >> 2) % 16);
    hit   = tbl[idx].valid && (tbl[idx].tag == (pc >> 6));
    taken = hit && (tbl[idx].conf >= 2);
    tgt   = taken ? tbl[idx].target : pc + 32'd4;
  endfunction

  // One cycle: drive inputs just after the edge, queue the expected response,
  // then advance the model to the state the next edge produces.
  task automatic step(input logic r, input logic [31:0] ipc, input logic uv,
                      input logic [31:0] upc, input logic ut, input logic [31:0] utg,
                      input logic upt, input logic [31:0] uptg);
    exp_t e;
    bit h, t, uh, ut_dummy;
    logic [31:0] tg, utg_dummy;
    int idx;
    @(posedge clk); #1;
    rst = r; if_pc = ipc; upd_valid = uv; upd_pc = upc; upd_taken = ut;
    upd_target = utg; upd_pred_taken = upt; upd_pred_target = uptg;
    predict(ipc, h, t, tg);
    e.hit    = r ? h : 1'b0;
    e.taken  = r ? t : 1'b0;
    e.target = r ? tg : ipc + 32'd4;
    e.misp   = r && uv && ((ut != upt) || (ut && (utg != uptg)));
    e.redir  = ut ? utg : upc + 32'd4;
    e.count  = 16'(m_count);
    sb.push_back(e);
    if (!r) begin
      model_reset();
    end else begin
      if (e.misp && m_count < 32'hFFFF) m_count++;
      if (uv) begin
        predict(upc, uh, ut_dummy, utg_dummy);
        idx = int'((upc >> 2) % 16);
        if (uh) begin
          if (ut) begin
            tbl[idx].conf   = (tbl[idx].conf < 3) ? tbl[idx].conf + 1 : 3;
            tbl[idx].target = utg;
          end else begin
            tbl[idx].conf = (tbl[idx].conf > 0) ? tbl[idx].conf - 1 : 0;
          end
        end else if (ut) begin
          tbl[idx].valid = 1; tbl[idx].tag = upc >> 6;
          tbl[idx].target = utg; tbl[idx].conf = 2;
        end
      end
    end
  endtask

  task automatic idle(input logic [31:0] ipc);
    step(1'b1, ipc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic upd(input logic [31:0] ipc, input logic [31:0] upc, input logic ut,
                     input logic [31:0] utg, input logic upt, input logic [31:0] uptg);
    step(1'b1, ipc, 1'b1, upc, ut, utg, upt, uptg);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("pred_hit", {31'd0, pred_hit}, {31'd0, e.hit});
      check("pred_taken", {31'd0, pred_taken}, {31'd0, e.taken});
      check("pred_target", pred_target, e.target);
      check("mispredict", {31'd0, mispredict}, {31'd0, e.misp});
      check("redirect_pc", redirect_pc, e.redir);
      check("mispredict_count", {16'd0, mispredict_count}, {16'd0, e.count});
    end
  end

  function automatic logic [31:0] rand_pc();
    logic [31:0] pool [9];
    pool = '{32'h100, 32'h140, 32'h180, 32'h1C0, 32'h104, 32'h200,
             32'hFFFF_FFFC, 32'h3C, 32'h0};
    pool[8] = $urandom() & 32'hFFFF_FFFC;
    return pool[$urandom_range(8)];
  endfunction

  initial begin
    bit h, t;
    logic [31:0] tg, p, tgt;
    int waited;
    rst = 1'b0; if_pc = 0; upd_valid = 0; upd_pc = 0; upd_taken = 0;
    upd_target = 0; upd_pred_taken = 0; upd_pred_target = 0;
    model_reset();
    step(1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Reset state, first allocation with a same-cycle fetch of the same PC.
    idle(32'h100);
    upd(32'h100, 32'h100, 1'b1, 32'h40, 1'b0, 32'h104);
    idle(32'h100);
    // Hysteresis: saturate, then two not-taken outcomes.
    upd(32'h100, 32'h100, 1'b1, 32'h40, 1'b1, 32'h40);
    upd(32'h100, 32'h100, 1'b1, 32'h40, 1'b1, 32'h40);
    upd(32'h100, 32'h100, 1'b0, 32'h40, 1'b1, 32'h40);
    idle(32'h100);
    upd(32'h100, 32'h100, 1'b0, 32'h40, 1'b1, 32'h40);
    idle(32'h100);
    // Aliasing and no-allocate on not-taken miss.
    upd(32'h100, 32'h100, 1'b1, 32'h40, 1'b0, 32'h104);
    upd(32'h140, 32'h140, 1'b1, 32'h80, 1'b0, 32'h144);
    idle(32'h100);
    idle(32'h140);
    upd(32'h200, 32'h200, 1'b0, 32'h0, 1'b0, 32'h204);
    idle(32'h200);
    // Taken/taken target mismatch.
    upd(32'h180, 32'h180, 1'b1, 32'h80, 1'b1, 32'h40);
    idle(32'hFFFF_FFFC);
    // Reset with an update present: discarded.
    step(1'b0, 32'h140, 1'b1, 32'h300, 1'b1, 32'h10, 1'b0, 32'h0);
    idle(32'h300);
    idle(32'h140);

    // Random traffic, predictions carried down from the model half the time.
    for (int i = 0; i < 3000; i++) begin
      p = rand_pc();
      tgt = ($urandom_range(1) == 1) ? 32'h40 : ($urandom() & 32'hFFFF_FFFC);
      predict(p, h, t, tg);
      if ($urandom_range(1) == 0) begin
        t  = $urandom_range(1);
        tg = $urandom() & 32'hFFFF_FFFC;
      end
      step(($urandom_range(63) != 0), rand_pc(), $urandom_range(1), p,
           $urandom_range(1), tgt, t, tg);
    end

    // Saturate the mispredict counter.
    for (int i = 0; i < 32'hFFFF + 2; i++)
      upd(rand_pc(), rand_pc(), 1'b1, 32'h80, 1'b0, 32'h0);
    idle(32'h100);

    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(negedge clk); waited++;
    end
    @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    check("count_saturated", {16'd0, mispredict_count}, 32'h0000_FFFF);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
